fetch_sequencer: RTL and testbench

- Controls the instruction fetch stage: owns the fetch PC and decides how many instructions (0..4) are requested from the icache each cycle.
- Fetch size is limited by instruction-buffer free slots and ROB free entries.
- Handles branch redirects with a one-cycle flush bubble, and a halt/drain state.
- Sits between the branch unit, instruction buffer, ROB and the fetch/decode datapath; its fetch_pc/num_fetch outputs drive the per-slot PC generation (slot i = fetch_pc + 2*i).

---
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch PC / group-size sequencer: owns the fetch PC, sizes each fetch group (0..FETCH_W)
// from ibuf/ROB credit, and handles redirect flush and halt. FETCH_ALIGN_EN keeps groups inside aligned blocks.
module fetch_sequencer #(
    parameter int FETCH_W = 4,
    parameter int PC_W    = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             halt_seen,
    input  logic [CNT_W-1:0] ibuf_free,
    input  logic [CNT_W-1:0] rob_free,
    input  logic             icache_ready,
    output logic             fetch_valid,
    output logic [PC_W-1:0]  fetch_pc,
    output logic [2:0]       num_fetch,
    output logic             flush,
    output logic [1:0]       seq_state
);
    localparam int AW = $clog2(FETCH_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [2:0]        num_q, num_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;

    logic              grant;
    logic [2:0]        g_num;
    logic [CNT_W-1:0]  g_cnt;
    logic [CNT_W-1:0]  ibuf_rem, rob_rem;
    logic [CNT_W-1:0]  n_w;
    logic [PC_W-1:0]   pc_adv;
`ifdef FETCH_ALIGN_EN
    logic [CNT_W-1:0]  room;
`endif

    assign grant    = valid_q & icache_ready;
    assign g_num    = grant ? num_q : 3'd0;
    assign g_cnt    = CNT_W'(g_num);
    assign pc_adv   = pc_q + PC_W'({g_num, 1'b0});
    assign ibuf_rem = (ibuf_free > g_cnt) ? ibuf_free - g_cnt : '0;
    assign rob_rem  = (rob_free > g_cnt) ? rob_free - g_cnt : '0;
`ifdef FETCH_ALIGN_EN
    assign room     = CNT_W'(FETCH_W) - CNT_W'(pc_adv[AW:1]);
`endif

    // Group size is always taken at the post-advance PC; in REDIRECT nothing is
    // valid, so pc_adv is simply the freshly loaded target.
    always_comb begin
        n_w = CNT_W'(FETCH_W);
        if (ibuf_rem < n_w) n_w = ibuf_rem;
        if (rob_rem < n_w)  n_w = rob_rem;
`ifdef FETCH_ALIGN_EN
        if (room < n_w)     n_w = room;
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        num_d   = num_q;
        valid_d = valid_q;
        flush_d = 1'b0;
        if (state_q == IDLE) begin
            state_d = RUN;
        end else if (is_jump) begin
            // Redirect wins over any concurrent grant; that grant is dropped.
            state_d = REDIRECT;
            pc_d    = jump_target;
            valid_d = 1'b0;
            num_d   = 3'd0;
            flush_d = 1'b1;
        end else if (state_q == RUN && halt_seen) begin
            state_d = HALT;
            pc_d    = pc_adv;
            valid_d = 1'b0;
            num_d   = 3'd0;
        end else if (state_q != HALT) begin
            state_d = RUN;
            if (!valid_q || grant) begin
                pc_d    = pc_adv;
                num_d   = 3'(n_w);
                valid_d = (n_w != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
        end
    end

    assign fetch_valid = valid_q;
    assign fetch_pc    = pc_q;
    assign num_fetch   = num_q;
    assign flush       = flush_q;
    assign seq_state   = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand sequences, and a random run
// checked against a cycle-level reference model.
module tb_fetch_sequencer;
`ifdef FETCH_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_jump = 1'b0;
    logic [15:0] jump_target = '0;
    logic        halt_seen = 1'b0;
    logic [4:0]  ibuf_free = 5'd16;
    logic [4:0]  rob_free = 5'd16;
    logic        icache_ready = 1'b1;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic [2:0]  num_fetch;
    logic        flush;
    logic [1:0]  seq_state;

    int n_chk = 0;
    int n_fail = 0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .is_jump(is_jump), .jump_target(jump_target),
        .halt_seen(halt_seen), .ibuf_free(ibuf_free), .rob_free(rob_free),
        .icache_ready(icache_ready), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .num_fetch(num_fetch), .flush(flush), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        jmp;
        logic [15:0] tgt;
        logic        hlt;
        logic [4:0]  ib;
        logic [4:0]  rb;
        logic        rdy;
        logic [1:0]  e_st;
        logic        e_v;
        logic [15:0] e_pc;
        logic [2:0]  e_n;
        logic        e_f;
    } vec_t;

    vec_t tq[$];

    // reference model state
    int m_st, m_pc, m_v, m_n, m_f;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input int st, input int v, input int pc,
                           input int n, input int f);
        chk($sformatf("%s.state", tag), 32'(seq_state), 32'(st));
        chk($sformatf("%s.valid", tag), 32'(fetch_valid), 32'(v));
        chk($sformatf("%s.pc", tag), 32'(fetch_pc), 32'(pc));
        chk($sformatf("%s.num", tag), 32'(num_fetch), 32'(n));
        chk($sformatf("%s.flush", tag), 32'(flush), 32'(f));
    endtask

    task automatic add(input logic jmp, input logic [15:0] tgt, input logic hlt,
                       input logic [4:0] ib, input logic [4:0] rb, input logic rdy,
                       input logic [1:0] st, input logic v, input logic [15:0] pc,
                       input logic [2:0] n, input logic f);
        vec_t t;
        t.jmp = jmp; t.tgt = tgt; t.hlt = hlt; t.ib = ib; t.rb = rb; t.rdy = rdy;
        t.e_st = st; t.e_v = v; t.e_pc = pc; t.e_n = n; t.e_f = f;
        tq.push_back(t);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock of the fetch rules, applied to the inputs present before the edge.
    task automatic model_step();
        int g, adv, n;
        bit gr;
        if (rst) begin
            m_st = 0; m_pc = 0; m_v = 0; m_n = 0; m_f = 0;
            return;
        end
        gr = (m_v != 0) && icache_ready;
        if (m_st == 0) begin
            m_st = 1;
        end else if (is_jump) begin
            m_st = 2; m_pc = int'(jump_target); m_v = 0; m_n = 0; m_f = 1;
        end else begin
            m_f = 0;
            g = gr ? m_n : 0;
            adv = (m_pc + 2 * g) % 65536;
            if (m_st == 1 && halt_seen) begin
                m_st = 3; m_pc = adv; m_v = 0; m_n = 0;
            end else if (m_st != 3) begin
                m_st = 1;
                if (m_v == 0 || gr) begin
                    n = imin(4, imin(imin(0, 0) + ((int'(ibuf_free) - g) > 0 ? int'(ibuf_free) - g : 0),
                                    ((int'(rob_free) - g) > 0 ? int'(rob_free) - g : 0)));
                    if (ALIGN) n = imin(n, 4 - (adv / 2) % 4);
                    m_pc = adv; m_n = n; m_v = (n > 0) ? 1 : 0;
                end
            end
        end
    endtask

    initial begin
        // reset state
        tick();
        tick();
        cmp_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        add(0, 16'h0,    0, 16, 16, 1, 1, 0, 16'h0,    0, 0);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, 16'h0,    4, 0);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, 16'h8,    4, 0);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, 16'h10,   4, 0);
        add(1, 16'h100,  0, 16, 16, 1, 2, 0, 16'h100,  0, 1);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, 16'h100,  4, 0);
        add(0, 16'h0,    0,  2, 16, 1, 1, 0, 16'h108,  0, 0);
        add(0, 16'h0,    0,  2, 16, 1, 1, 1, 16'h108,  2, 0);
        for (int i = 0; i < 3; i++)
            add(0, 16'h0, 0,  2, 16, 0, 1, 1, 16'h108,  2, 0);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, 16'h10C,  ALIGN ? 3'd2 : 3'd4, 0);
        add(0, 16'h0,    1, 16, 16, 0, 3, 0, 16'h10C,  0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 16'h0, 1'(i % 2), 16, 16, 1, 3, 0, 16'h10C, 0, 0);
        add(1, 16'h40,   0, 16, 16, 1, 2, 0, 16'h40,   0, 1);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, 16'h40,   4, 0);
        add(1, 16'hFFFC, 0, 16, 16, 1, 2, 0, 16'hFFFC, 0, 1);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, 16'hFFFC, ALIGN ? 3'd2 : 3'd4, 0);
        add(0, 16'h0,    0, 16,  0, 1, 1, 0, ALIGN ? 16'h0 : 16'h4, 0, 0);
        add(0, 16'h0,    0, 16,  0, 1, 1, 0, ALIGN ? 16'h0 : 16'h4, 0, 0);
        add(1, 16'h6,    0, 16, 16, 1, 2, 0, 16'h6,    0, 1);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, 16'h6,    ALIGN ? 3'd1 : 3'd4, 0);
        add(0, 16'h0,    0, 16, 16, 1, 1, 1, ALIGN ? 16'h8 : 16'hE, 4, 0);

        foreach (tq[i]) begin
            is_jump = tq[i].jmp; jump_target = tq[i].tgt; halt_seen = tq[i].hlt;
            ibuf_free = tq[i].ib; rob_free = tq[i].rb; icache_ready = tq[i].rdy;
            tick();
            cmp_all($sformatf("vec%0d", i), tq[i].e_st, tq[i].e_v, tq[i].e_pc, tq[i].e_n, tq[i].e_f);
        end

        // back-to-back redirects: flush stays high, second target wins
        ibuf_free = 16; rob_free = 16; icache_ready = 1'b1; halt_seen = 1'b0;
        is_jump = 1'b1; jump_target = 16'h200;
        tick();
        cmp_all("jj1", 2, 0, 16'h200, 0, 1);
        jump_target = 16'h300;
        tick();
        cmp_all("jj2", 2, 0, 16'h300, 0, 1);
        is_jump = 1'b0;
        tick();
        cmp_all("jj3", 1, 1, 16'h300, 4, 0);

        // asynchronous reset in the middle of a stalled handshake
        icache_ready = 1'b0;
        tick();
        cmp_all("stall", 1, 1, 16'h300, 4, 0);
        #2 rst = 1'b1;
        #1;
        cmp_all("async_rst", 0, 0, 0, 0, 0);
        icache_ready = 1'b1;
        tick();
        cmp_all("rst_hold", 0, 0, 0, 0, 0);

        // random run against the reference model
        model_step();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            is_jump      = ($urandom_range(0, 99) < 8);
            jump_target  = 16'($urandom());
            halt_seen    = ($urandom_range(0, 99) < 4);
            ibuf_free    = 5'($urandom_range(0, 20));
            rob_free     = 5'($urandom_range(0, 20));
            icache_ready = ($urandom_range(0, 99) < 70);
            model_step();
            tick();
            cmp_all($sformatf("rnd%0d", c), m_st, m_v, m_pc, m_n, m_f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
